// File: rtl/regfile_pkg.sv
// Shared definitions for the dual-read register file.
// Contents:
//   DEFAULT_WIDTH / DEFAULT_NREGS - default datapath width and register count
//   RESET_VALUE                   - all-zeros reset value, DEFAULT_WIDTH bits
//   idx_width(n)                  - index width max(1, clog2(n)), n in 1..32
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_NREGS = 8;

  localparam logic [DEFAULT_WIDTH-1:0] RESET_VALUE = '0;

  // Bounded loop so the function elaborates as a constant in any tool.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i <= 5; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dff_en_ar.sv
// Parametrised-width D flip-flop with load enable and asynchronous
// active-low clear.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear to RST_VAL
//   en    - load enable; q holds when low
//   d     - data in (W bits)
//   q     - registered data out (W bits)
module dff_en_ar #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_dual_read.sv
// Parametrised register file: NREGS x WIDTH, one synchronous write port,
// two independent combinational read ports with write-first forwarding,
// each feeding an enabled output register (A, B) for the ALU operands.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   write, writenum       - write enable and destination index
//   data_in               - write data
//   readnum_a, readnum_b  - source indices for ports A and B
//   loada, loadb          - capture enables for A and B
//   A, B                  - latched operands
// Indices >= NREGS: writes are dropped, reads return 0.
// Optional build macro REGFILE_ZERO_R0_EN: register 0 is hardwired to zero,
// writes to it are dropped and never forwarded; no storage is built for it.
module regfile_dual_read
  import regfile_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int NREGS = DEFAULT_NREGS,
  localparam int AW    = idx_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write,
  input  logic [AW-1:0]    writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  input  logic             loada,
  input  logic             loadb,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

`ifdef REGFILE_ZERO_R0_EN
  localparam int FIRST_REG = 1;  // register 0 is a constant zero
`else
  localparam int FIRST_REG = 0;
`endif

  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_ok;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // A write is effective only for an index that has real storage.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ok = 1'b0;
    for (int i = FIRST_REG; i < NREGS; i++) begin
      if (writenum == AW'(i)) wr_ok = write;
    end
  end

  // Storage: each register is its own resettable flop, so the whole file
  // clears asynchronously with rst_n.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i < FIRST_REG) begin : g_zero
      assign regs[i] = RST_VAL;
    end else begin : g_ff
      dff_en_ar #(.W(WIDTH), .RST_VAL(RST_VAL)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_ok && (writenum == AW'(i))),
        .d     (data_in),
        .q     (regs[i])
      );
    end
  end

  // Read with out-of-range -> 0, then write-first bypass so a capture on
  // the writing edge already sees the new value.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] sel);
    logic [WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel == AW'(i)) val = regs[i];
    end
    if (wr_ok && (writenum == sel)) val = data_in;
    return val;
  endfunction

  always_comb begin
    rd_a = read_port(readnum_a);
    rd_b = read_port(readnum_b);
  end

  dff_en_ar #(.W(WIDTH), .RST_VAL(RST_VAL)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (loada),
    .d     (rd_a),
    .q     (A)
  );

  dff_en_ar #(.W(WIDTH), .RST_VAL(RST_VAL)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (loadb),
    .d     (rd_b),
    .q     (B)
  );

endmodule

// File: tb/tb_regfile_dual_read.sv
// Self-checking bench for regfile_dual_read. Main instance uses defaults
// (8 x 16); a second 6-register instance covers out-of-range indices.
// Expected operands come from a behavioural model and pass through a
// scoreboard queue. Honours REGFILE_ZERO_R0_EN in its model.
module tb_regfile_dual_read;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int N6 = 6;

`ifdef REGFILE_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         write;
  logic [2:0]   writenum;
  logic [W-1:0] data_in;
  logic [2:0]   readnum_a;
  logic [2:0]   readnum_b;
  logic         loada;
  logic         loadb;
  logic [W-1:0] A;
  logic [W-1:0] B;

  logic         write6;
  logic [2:0]   writenum6;
  logic [W-1:0] data_in6;
  logic [2:0]   readnum_a6;
  logic [2:0]   readnum_b6;
  logic         loada6;
  logic         loadb6;
  logic [W-1:0] A6;
  logic [W-1:0] B6;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] mreg [N];
  logic [W-1:0] ma;
  logic [W-1:0] mb;
  exp_t         sb [$];

  regfile_dual_read dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in),
    .readnum_a (readnum_a),
    .readnum_b (readnum_b),
    .loada     (loada),
    .loadb     (loadb),
    .A         (A),
    .B         (B)
  );

  regfile_dual_read #(.WIDTH(W), .NREGS(N6)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .write     (write6),
    .writenum  (writenum6),
    .data_in   (data_in6),
    .readnum_a (readnum_a6),
    .readnum_b (readnum_b6),
    .loada     (loada6),
    .loadb     (loadb6),
    .A         (A6),
    .B         (B6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of the current-cycle read value seen by a capture.
  function automatic logic [W-1:0] model_read(input logic [2:0] sel,
      input logic w, input logic [2:0] wn, input logic [W-1:0] d);
    if (ZERO_R0 && sel == 3'd0) return '0;
    if (w && wn == sel) return d;
    return mreg[sel];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mreg[i] = '0;
    ma = '0;
    mb = '0;
    sb.delete();
  endtask

  // One clock of stimulus: drive at negedge, push expectation, compare
  // #1 after the capturing edge, then advance the model.
  task automatic drive(input string tag, input logic w, input logic [2:0] wn,
      input logic [W-1:0] d, input logic [2:0] ra, input logic [2:0] rb,
      input logic la, input logic lb);
    exp_t e;
    exp_t got;
    @(negedge clk);
    write = w; writenum = wn; data_in = d;
    readnum_a = ra; readnum_b = rb; loada = la; loadb = lb;
    e.a = la ? model_read(ra, w, wn, d) : ma;
    e.b = lb ? model_read(rb, w, wn, d) : mb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'hDEAD, 16'h0000);
    end else begin
      got = sb.pop_front();
      check({tag, "_A"}, A, got.a);
      check({tag, "_B"}, B, got.b);
      ma = got.a;
      mb = got.b;
    end
    if (w && !(ZERO_R0 && wn == 3'd0)) mreg[wn] = d;
  endtask

  task automatic drive6(input logic w, input logic [2:0] wn,
      input logic [W-1:0] d, input logic [2:0] ra, input logic [2:0] rb,
      input logic la, input logic lb);
    @(negedge clk);
    write6 = w; writenum6 = wn; data_in6 = d;
    readnum_a6 = ra; readnum_b6 = rb; loada6 = la; loadb6 = lb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    write = 0; writenum = 0; data_in = 0; readnum_a = 0; readnum_b = 0;
    loada = 0; loadb = 0;
    write6 = 0; writenum6 = 0; data_in6 = 0; readnum_a6 = 0; readnum_b6 = 0;
    loada6 = 0; loadb6 = 0;
    model_clear();
    #2;
    check("reset_A", A, '0);
    check("reset_B", B, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load non-zero values, then assert reset mid-cycle with a pending
    // write and captures: everything must clear immediately.
    drive("pre_wr", 1, 3'd2, 16'hAAAA, 3'd2, 3'd0, 1, 0);
    drive("pre_ldb", 0, 3'd0, 16'h0, 3'd0, 3'd2, 0, 1);
    @(negedge clk);
    write = 1; writenum = 3'd3; data_in = 16'h5555;
    readnum_a = 3'd2; readnum_b = 3'd3; loada = 1; loadb = 1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_A", A, '0);
    check("midrst_B", B, '0);
    @(posedge clk);
    #1;
    check("rst_dom_A", A, '0);
    check("rst_dom_B", B, '0);
    @(negedge clk);
    write = 0; loada = 0; loadb = 0;
    rst_n = 1'b1;
    model_clear();

    for (int i = 0; i < N; i++) drive("post_rst_rd", 0, 3'd0, 16'h0, 3'(i), 3'(i), 1, 1);

    // Write then readback; B must hold with loadb low.
    drive("wr_r3", 1, 3'd3, 16'hBEEF, 3'd0, 3'd0, 0, 0);
    drive("rd_r3", 0, 3'd0, 16'h0, 3'd3, 3'd3, 1, 0);

    // Same-cycle forwarding to both ports.
    drive("wr_r5", 1, 3'd5, 16'h1111, 3'd0, 3'd0, 0, 0);
    drive("fwd_r5", 1, 3'd5, 16'h2222, 3'd5, 3'd5, 1, 1);
    drive("rd_r5", 0, 3'd0, 16'h0, 3'd5, 3'd0, 1, 0);

    // Independent dual read, then hold on B.
    drive("wr_r1", 1, 3'd1, 16'h00AA, 3'd0, 3'd0, 0, 0);
    drive("wr_r6", 1, 3'd6, 16'h5500, 3'd0, 3'd0, 0, 0);
    drive("dual", 0, 3'd0, 16'h0, 3'd1, 3'd6, 1, 1);
    drive("hold_b", 0, 3'd0, 16'h0, 3'd6, 3'd1, 1, 0);

    // Register 0 write with same-cycle read (macro-dependent result).
    drive("wr_r0_fwd", 1, 3'd0, 16'h1234, 3'd0, 3'd7, 1, 1);
    drive("rd_r0", 0, 3'd0, 16'h0, 3'd0, 3'd0, 1, 1);
    drive("rd_r7", 1, 3'd7, 16'hF00F, 3'd7, 3'd7, 0, 1);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      drive("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    write = 0; loada = 0; loadb = 0;

    // Six-register instance: out-of-range writes dropped, reads return 0.
    drive6(1, 3'd5, 16'h0505, 3'd5, 3'd0, 1, 0);
    check("n6_fwd_top", A6, 16'h0505);
    drive6(1, 3'd7, 16'hFFFF, 3'd7, 3'd5, 1, 1);
    check("n6_oor7_A", A6, 16'h0000);
    check("n6_oor7_B", B6, 16'h0505);
    drive6(1, 3'd6, 16'hFFFF, 3'd6, 3'd6, 1, 1);
    check("n6_oor6_A", A6, 16'h0000);
    check("n6_oor6_B", B6, 16'h0000);
    for (int i = 0; i < N6; i++) begin
      drive6(0, 3'd0, 16'h0, 3'(i), 3'(i), 1, 1);
      check("n6_scan_A", A6, (i == 5) ? 16'h0505 : 16'h0000);
      check("n6_scan_B", B6, (i == 5) ? 16'h0505 : 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dual_read.md
Name: regfile_dual_read

Overview:
Parametrised datapath register file: NREGS registers of WIDTH bits, one synchronous write port and two independent read ports.
- Each read port feeds its own enabled output latch (A, B), which drives the ALU operand inputs.
- Successor to the fixed 8x16 single-read-mux design: read selects are independent per port, and same-cycle write-to-read forwarding is added.

Parameters:
WIDTH, 16, bit width of each register and of data_in/A/B
NREGS, 8, number of architectural registers (2..32, need not be a power of two)
(localparam AW = max(1, clog2(NREGS)), index width)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
write  input  1  write enable for register writenum
writenum  input  AW  destination register index
data_in  input  WIDTH  write data
readnum_a  input  AW  source index for port A
readnum_b  input  AW  source index for port B
loada  input  1  capture port-A read value into A
loadb  input  1  capture port-B read value into B
A  output  WIDTH  latched operand A
B  output  WIDTH  latched operand B

Behaviour:
- Reset: rst_n low clears all NREGS registers, A and B to 0 immediately, independent of clk. Reset dominates write/loada/loadb. Reset asserted mid-cycle discards any pending write or capture. First capture/write takes effect on the first rising edge after rst_n rises.
- Write: on posedge with write=1 and writenum<NREGS, reg[writenum] <= data_in. writenum>=NREGS: write dropped, no register changes.
- Read value: rd_x = reg[readnum_x] combinationally. readnum_x>=NREGS reads 0.
- Forwarding: if write=1 and writenum==readnum_x (valid index) in the same cycle, rd_x = data_in (write-first). Capture on that edge sees the new value.
- Capture: on posedge, A <= rd_a if loada, else A holds. B <= rd_b if loadb, else B holds. Latency is 1 edge from loada/loadb to updated A/B.
- Simultaneous events:
  - loada and loadb may be asserted together, including with readnum_a==readnum_b; both get the same value.
  - Write and both captures in one cycle are legal; all three update on the same edge.
- No internal FSM beyond register state. A/B change only on a capture edge or reset.
- X-handling: an X on readnum_x with loada=1 may load X into A. Nothing else is corrupted.

Optional Feature:
REGFILE_ZERO_R0_EN
- Defined:
  - reg[0] is hardwired to 0; writes to index 0 are dropped.
  - Forwarding is suppressed when writenum==0, so reading index 0 always returns 0.
  - Storage for reg[0] is not synthesised.
- Undefined: reg[0] is an ordinary register, identical to the others.

Decomposition:
- Shared package regfile_pkg:
  - default WIDTH/NREGS constants;
  - a clog2-style index-width function;
  - a reset-value constant (all-zeros, WIDTH bits).
- One sub-module, dff_en_ar: parametrised-width D flip-flop with enable and asynchronous active-low clear. Instantiated for A, B and each register (generate loop).
- Read muxes and forwarding compare stay inline in regfile_dual_read.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with loada=1 -> A=B=0 immediately. All regs read 0 after release (loada=1, readnum_a=0..7 -> A=0x0000 each).
- Write/readback: write r3=0xBEEF, then readnum_a=3, loada=1 -> A=0xBEEF on the next edge. B unchanged while loadb=0.
- Forwarding: with r5=0x1111, in one cycle set write=1, writenum=5, data_in=0x2222, readnum_a=5, readnum_b=5, loada=loadb=1 -> A=B=0x2222. Later read of r5 -> 0x2222.
- Dual independent read: r1=0x00AA, r6=0x5500; readnum_a=1, readnum_b=6, both loads -> A=0x00AA, B=0x5500. Next cycle loadb=0, readnum_b=1 -> B holds 0x5500.
- Out-of-range (NREGS=6): write=1, writenum=7, data_in=0xFFFF -> no register changes. readnum_a=7, loada=1 -> A=0x0000.
- REGFILE_ZERO_R0_EN: write r0=0x1234, same-cycle readnum_a=0, loada=1 -> A=0x0000. Without the macro: A=0x1234 via forwarding.
